// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle between two pipeline stages around a pipe_stage_skid.
// The master side is the surrounding pipeline (producer and consumer); the slave side is the stage register.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 96,
    parameter int REG_W  = 5,
    parameter int TNEW_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_pc;
    logic [REG_W-1:0]  in_reg;
    logic [TNEW_W-1:0] in_tnew;
    logic [4:0]        in_exc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic [REG_W-1:0]  out_reg;
    logic [TNEW_W-1:0] out_tnew;
    logic [4:0]        out_exc;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_pc, in_reg, in_tnew, in_exc, out_ready,
        input  in_ready, out_valid, out_data, out_pc, out_reg, out_tnew, out_exc, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_pc, in_reg, in_tnew, in_exc, out_ready,
        output in_ready, out_valid, out_data, out_pc, out_reg, out_tnew, out_exc, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer for the five-stage MIPS core.
// Carries payload plus hazard fields (PC, destination register, T_new, ExcCode).
// in_ready depends only on registered occupancy, so stall back-pressure never forms a
// combinational path from out_ready back to in_ready. Flush leaves a bubble carrying flush_pc.
module pipe_stage_skid #(
    parameter int          DATA_W   = 96,
    parameter int          REG_W    = 5,
    parameter int          TNEW_W   = 3,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [31:0]          flush_pc,
    pipe_stage_skid_if.slave     bus
);

    // Occupancy doubles as the state encoding: the state value is the number of held entries.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
        logic [REG_W-1:0]  rd;
        logic [TNEW_W-1:0] tnew;
        logic [4:0]        exc;
    } entry_t;

    // T_new counts down by one stage on capture and never wraps below zero.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        logic [TNEW_W-1:0] one;
        one = {{(TNEW_W-1){1'b0}}, 1'b1};
        return (t != '0) ? (t - one) : '0;
    endfunction

    state_t r_state;
    state_t w_state_nxt;
    entry_t r_head;
    entry_t r_skid;
    entry_t w_head_nxt;
    entry_t w_skid_nxt;
    entry_t w_cap;

    logic w_in_ready;
    logic w_head_vld;
    logic w_accept;
    logic w_release;

    assign w_in_ready = (r_state != S_TWO);
    assign w_head_vld = (r_state != S_EMPTY);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_release  = w_head_vld & bus.out_ready;

    // Build the entry as it will be stored: only T_new is transformed.
    always_comb begin
        w_cap      = '0;
        w_cap.data = bus.in_data;
        w_cap.pc   = bus.in_pc;
        w_cap.rd   = bus.in_reg;
        w_cap.tnew = sat_dec(bus.in_tnew);
        w_cap.exc  = bus.in_exc;
    end

    // Next-state and entry movement; flush overrides every accept/release in its cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt   = S_EMPTY;
            w_head_nxt.pc = flush_pc;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_head_nxt  = w_cap;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_release && w_accept) begin
                        w_head_nxt = w_cap;
                    end else if (w_release) begin
                        // Head PC is kept so an empty stage still shows the last released PC.
                        w_state_nxt = S_EMPTY;
                    end else if (w_accept) begin
                        w_skid_nxt  = w_cap;
                        w_state_nxt = S_TWO;
                    end
                end
                S_TWO: begin
                    if (w_release) begin
                        w_head_nxt  = r_skid;
                        w_state_nxt = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers; reset takes priority over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_head  <= '{data: '0, pc: PC_RESET, rd: '0, tnew: '0, exc: '0};
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Output gating: invalid head shows zeros except the bubble PC; a faulting head never writes a register.
    always_comb begin
        bus.out_valid = w_head_vld;
        bus.out_pc    = r_head.pc;
        bus.out_data  = '0;
        bus.out_reg   = '0;
        bus.out_tnew  = '0;
        bus.out_exc   = '0;
        if (w_head_vld) begin
            bus.out_data = r_head.data;
            bus.out_tnew = r_head.tnew;
            bus.out_exc  = r_head.exc;
            bus.out_reg  = (r_head.exc != 5'd0) ? '0 : r_head.rd;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: throughput, back-pressure, T_new saturation,
// exception gating, flush and reset behaviour.
module tb_pipe_stage_skid;
    localparam int DATA_W = 96;
    localparam int REG_W  = 5;
    localparam int TNEW_W = 3;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;

    int checks;
    int errors;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .REG_W(REG_W), .TNEW_W(TNEW_W)) bus ();

    pipe_stage_skid #(
        .DATA_W(DATA_W), .REG_W(REG_W), .TNEW_W(TNEW_W), .PC_RESET(32'h0000_3000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .flush_pc(flush_pc),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [TNEW_W-1:0] tn,
                          input logic [REG_W-1:0] rd, input logic [4:0] exc, input logic [DATA_W-1:0] d);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_tnew  = tn;
        bus.in_reg   = rd;
        bus.in_exc   = exc;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h want 00003000", bus.out_pc); end
        checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.out_data !== '0 || bus.out_reg !== '0 || bus.out_tnew !== '0 || bus.out_exc !== '0) begin
            errors++; $display("FAIL reset_fields got data=%h reg=%0d tnew=%0d exc=%0d want 0", bus.out_data, bus.out_reg, bus.out_tnew, bus.out_exc);
        end
    endtask

    task automatic test_throughput();
        logic [31:0] pc;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            set_in(1'b1, pc, 3'd2, 5'd3, 5'd0, DATA_W'(32'hA000 + i));
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== pc) begin
                errors++; $display("FAIL tput_head[%0d] got valid=%0b pc=%h want 1 %h", i, bus.out_valid, bus.out_pc, pc);
            end
            checks++; if (bus.out_tnew !== 3'd1 || bus.occupancy !== 2'd1) begin
                errors++; $display("FAIL tput_tnew_occ[%0d] got tnew=%0d occ=%0d want 1 1", i, bus.out_tnew, bus.occupancy);
            end
            checks++; if (bus.out_data !== DATA_W'(32'hA000 + i)) begin
                errors++; $display("FAIL tput_data[%0d] got %h want %h", i, bus.out_data, DATA_W'(32'hA000 + i));
            end
        end
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.out_pc !== 32'h300C) begin
            errors++; $display("FAIL tput_drain got valid=%0b occ=%0d pc=%h want 0 0 0000300c", bus.out_valid, bus.occupancy, bus.out_pc);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h3000, 3'd1, 5'd1, 5'd0, DATA_W'(1));
        tick();
        checks++; if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first got occ=%0d rdy=%0b want 1 1", bus.occupancy, bus.in_ready);
        end
        set_in(1'b1, 32'h3004, 3'd1, 5'd2, 5'd0, DATA_W'(2));
        tick();
        checks++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_pc !== 32'h3000) begin
            errors++; $display("FAIL bp_full got occ=%0d rdy=%0b pc=%h want 2 0 00003000", bus.occupancy, bus.in_ready, bus.out_pc);
        end
        set_in(1'b1, 32'h3008, 3'd1, 5'd3, 5'd0, DATA_W'(3));
        tick();
        checks++; if (bus.occupancy !== 2'd2 || bus.out_pc !== 32'h3000) begin
            errors++; $display("FAIL bp_hold got occ=%0d pc=%h want 2 00003000", bus.occupancy, bus.out_pc);
        end
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_pc !== 32'h3004 || bus.out_data !== DATA_W'(2) || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_rel1 got pc=%h data=%0d occ=%0d rdy=%0b want 00003004 2 1 1", bus.out_pc, bus.out_data, bus.occupancy, bus.in_ready);
        end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.out_pc !== 32'h3004) begin
            errors++; $display("FAIL bp_rel2 got valid=%0b occ=%0d pc=%h want 0 0 00003004 (3008 must be dropped)", bus.out_valid, bus.occupancy, bus.out_pc);
        end
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h3010, 3'd0, 5'd4, 5'd0, DATA_W'(4));
        tick();
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tnew !== 3'd0) begin
            errors++; $display("FAIL sat_zero got valid=%0b tnew=%0d want 1 0", bus.out_valid, bus.out_tnew);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h3014, 3'd7, 5'd5, 5'd0, DATA_W'(5));
        tick();
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        checks++; if (bus.out_tnew !== 3'd6) begin
            errors++; $display("FAIL sat_seven got tnew=%0d want 6", bus.out_tnew);
        end
        repeat (5) tick();
        checks++; if (bus.out_tnew !== 3'd6 || bus.occupancy !== 2'd1 || bus.out_pc !== 32'h3014) begin
            errors++; $display("FAIL sat_hold got tnew=%0d occ=%0d pc=%h want 6 1 00003014", bus.out_tnew, bus.occupancy, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_exception();
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h3020, 3'd1, 5'd8, 5'd4, DATA_W'(6));
        tick();
        checks++; if (bus.out_reg !== 5'd0 || bus.out_exc !== 5'd4) begin
            errors++; $display("FAIL exc_gate got reg=%0d exc=%0d want 0 4", bus.out_reg, bus.out_exc);
        end
        bus.out_ready = 1'b1;
        set_in(1'b1, 32'h3024, 3'd1, 5'd8, 5'd0, DATA_W'(7));
        tick();
        checks++; if (bus.out_reg !== 5'd8 || bus.out_exc !== 5'd0 || bus.out_pc !== 32'h3024) begin
            errors++; $display("FAIL exc_none got reg=%0d exc=%0d pc=%h want 8 0 00003024", bus.out_reg, bus.out_exc, bus.out_pc);
        end
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        tick();
        checks++; if (bus.out_reg !== 5'd0 || bus.out_data !== '0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL exc_empty got reg=%0d data=%h valid=%0b want 0 0 0", bus.out_reg, bus.out_data, bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h3030, 3'd2, 5'd9, 5'd0, DATA_W'(8));
        tick();
        set_in(1'b1, 32'h3034, 3'd2, 5'd10, 5'd0, DATA_W'(9));
        tick();
        checks++; if (bus.occupancy !== 2'd2) begin
            errors++; $display("FAIL flush_fill got occ=%0d want 2", bus.occupancy);
        end
        flush = 1'b1;
        flush_pc = 32'h4180;
        set_in(1'b1, 32'h5000, 3'd2, 5'd11, 5'd0, DATA_W'(10));
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h4180 || bus.occupancy !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full got valid=%0b pc=%h occ=%0d rdy=%0b want 0 00004180 0 1", bus.out_valid, bus.out_pc, bus.occupancy, bus.in_ready);
        end
        // Flush with one entry while both accept and release are offered: both discarded.
        set_in(1'b1, 32'h3040, 3'd2, 5'd12, 5'd0, DATA_W'(11));
        tick();
        bus.out_ready = 1'b1;
        flush = 1'b1;
        flush_pc = 32'h4200;
        set_in(1'b1, 32'h3044, 3'd2, 5'd13, 5'd0, DATA_W'(12));
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.out_pc !== 32'h4200) begin
            errors++; $display("FAIL flush_one got valid=%0b occ=%0d pc=%h want 0 0 00004200", bus.out_valid, bus.occupancy, bus.out_pc);
        end
        tick();
        checks++; if (bus.occupancy !== 2'd0 || bus.out_pc !== 32'h4200) begin
            errors++; $display("FAIL flush_after got occ=%0d pc=%h want 0 00004200", bus.occupancy, bus.out_pc);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h3050, 3'd3, 5'd14, 5'd2, DATA_W'(13));
        tick();
        set_in(1'b1, 32'h3054, 3'd3, 5'd15, 5'd0, DATA_W'(14));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_reg !== '0 || bus.out_tnew !== '0 || bus.out_exc !== '0) begin
            errors++; $display("FAIL rst_mid_fields got valid=%0b data=%h reg=%0d tnew=%0d exc=%0d want all 0", bus.out_valid, bus.out_data, bus.out_reg, bus.out_tnew, bus.out_exc);
        end
        checks++; if (bus.out_pc !== 32'h3000 || bus.occupancy !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ctrl got pc=%h occ=%0d rdy=%0b want 00003000 0 1", bus.out_pc, bus.occupancy, bus.in_ready);
        end
        flush = 1'b1;
        flush_pc = 32'h4180;
        tick();
        flush = 1'b0;
        checks++; if (bus.out_pc !== 32'h4180) begin
            errors++; $display("FAIL rst_pre_flush got pc=%h want 00004180", bus.out_pc);
        end
        reset = 1'b1;
        flush = 1'b1;
        flush_pc = 32'h4180;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        checks++; if (bus.out_pc !== 32'h3000 || bus.occupancy !== 2'd0) begin
            errors++; $display("FAIL rst_with_flush got pc=%h occ=%0d want 00003000 0", bus.out_pc, bus.occupancy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        flush = 1'b0;
        flush_pc = 32'h0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 32'h0, 3'd0, 5'd0, 5'd0, '0);
        test_reset();
        test_throughput();
        test_backpressure();
        test_saturation();
        test_exception();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
